// File: rtl/salsa_core_ctrl_if.sv
// salsa_core_ctrl_if: valid/ready bundle carrying 512-bit Salsa20 states into and out of the core.
interface salsa_core_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/salsa_core_ctrl.sv
// salsa_core_ctrl: runs ROUNDS Salsa20 half-rounds through one shared quarter-round, one per clock.
// Define SALSA_FEEDFORWARD_EN to add the accepted state to the permuted result (standard core output).
module salsa_quarter_sha (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    assign o_b = i_b ^ rotl(i_a + i_d, 7);
    assign o_c = i_c ^ rotl(o_b + i_a, 9);
    assign o_d = i_d ^ rotl(o_c + o_b, 13);
    assign o_a = i_a ^ rotl(o_d + o_c, 18);
endmodule

module salsa_core_ctrl #(
    parameter int ROUNDS = 20
) (
    input logic               clk,
    input logic               rst_n,
    salsa_core_ctrl_if.slave  bus
);
    localparam int STEP_W = $clog2(4 * ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [STEP_W-1:0]   r_step;
    logic [31:0]         r_work [16];
`ifdef SALSA_FEEDFORWARD_EN
    logic [31:0]         r_orig [16];
`endif
    logic                r_out_valid;
    logic [511:0]        r_out_state;
    logic [1:0]          w_q;
    logic [3:0]          w_q4;
    logic                w_row;
    logic                w_last;
    logic [3:0]          w_ia, w_ib, w_ic, w_id;
    logic [31:0]         w_oa, w_ob, w_oc, w_od;

    // Column round walks the diagonal a=5q with b,c,d four apart; row round keeps a=5q and
    // rotates the other three words within row q.
    assign w_q    = r_step[1:0];
    assign w_q4   = {2'b00, w_q};
    assign w_row  = |(r_step & STEP_W'(4));
    assign w_last = (r_step == STEP_W'(4 * ROUNDS - 1));
    assign w_ia   = w_q4 * 4'd5;
    assign w_ib   = w_row ? {w_q, w_q + 2'd1} : w_ia + 4'd4;
    assign w_ic   = w_row ? {w_q, w_q + 2'd2} : w_ia + 4'd8;
    assign w_id   = w_row ? {w_q, w_q + 2'd3} : w_ia + 4'd12;

    salsa_quarter_sha u_qr (
        .i_a (r_work[w_ia]),
        .i_b (r_work[w_ib]),
        .i_c (r_work[w_ic]),
        .i_d (r_work[w_id]),
        .o_a (w_oa),
        .o_b (w_ob),
        .o_c (w_oc),
        .o_d (w_od)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.in_ready = (r_state == IDLE);
        bus.busy     = (r_state != IDLE);
        case (r_state)
            IDLE:    w_next = bus.in_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? FINAL : RUN;
            FINAL:   w_next = DONE;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            for (int i = 0; i < 16; i++) begin
                r_work[i] <= '0;
`ifdef SALSA_FEEDFORWARD_EN
                r_orig[i] <= '0;
`endif
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_step <= '0;
                        for (int i = 0; i < 16; i++) begin
                            r_work[i] <= bus.in_state[32*i +: 32];
`ifdef SALSA_FEEDFORWARD_EN
                            r_orig[i] <= bus.in_state[32*i +: 32];
`endif
                        end
                    end
                end
                RUN: begin
                    r_work[w_ia] <= w_oa;
                    r_work[w_ib] <= w_ob;
                    r_work[w_ic] <= w_oc;
                    r_work[w_id] <= w_od;
                    r_step       <= r_step + STEP_W'(1);
                end
                FINAL: begin
                    r_out_valid <= 1'b1;
                    for (int i = 0; i < 16; i++) begin
`ifdef SALSA_FEEDFORWARD_EN
                        r_out_state[32*i +: 32] <= r_work[i] + r_orig[i];
`else
                        r_out_state[32*i +: 32] <= r_work[i];
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_out_state;
endmodule

// File: doc/salsa_core_ctrl.md
Name: salsa_core_ctrl

Overview:
- Sequences a single shared Salsa20 quarter-round datapath (QUARTER_SHA) over a 16-word state to compute the Salsa20 core hash.
- Runs ROUNDS half-rounds as alternating column and row rounds, one quarter-round per clock, then an optional feed-forward add.
- Sits between a keystream/nonce-counter front end and the output buffer. Uses a valid/ready handshake on both sides.

Parameters:
- ROUNDS, 20, number of half-rounds (column, row, column, ...); any value >=1 is legal; 8/12/20 are the supported variants.
- STEP_W, $clog2(4*ROUNDS), width of the step counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  512  word i at bits [32i+31:32i], i=0..15
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  512  result, same word packing as in_state
- busy  output  1  high from accept until the output handshake completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_state=0, busy=0, step=0, work/orig registers=0. in_ready=1 after reset because it decodes IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_state into both work and orig, clear step, go to RUN.
  - RUN: each cycle, apply one QUARTER_SHA to four work words and write its four outputs back to the same indices. Then step++. When step==4*ROUNDS-1, go to FINAL after the write.
  - FINAL: one cycle. Register out_state (see Optional Feature), set out_valid=1, go to DONE.
  - DONE: hold out_state and out_valid until out_valid&out_ready. Then clear out_valid and return to IDLE. In_ready stays low, so there is no back-to-back accept in the same cycle.
- Quarter-round mapping: q=step[1:0]; half-round h=step/4; even h is a column round, odd h is a row round. Words are listed in (a,b,c,d) order.
  - Column round: q0=(0,4,8,12), q1=(5,9,13,1), q2=(10,14,2,6), q3=(15,3,7,11).
  - Row round: q0=(0,1,2,3), q1=(5,6,7,4), q2=(10,11,8,9), q3=(15,12,13,14).
- Arithmetic: all adds are 32-bit modulo 2^32 and the carry is discarded. The quarter-round instance is purely combinational and is instantiated exactly once.
- Latency: if the accept edge is cycle 0, out_valid rises at the edge ending cycle 4*ROUNDS+1. For ROUNDS=20, out_valid is visible in cycle 82.
- Ignored inputs: in_valid outside IDLE is ignored and in_state is not sampled. out_ready outside DONE is ignored.
- Throughput: one hash per 4*ROUNDS+3 cycles when out_ready is held high.
- Reset mid-operation: rst_n=0 in any state forces the reset values at that edge, so a partial result is never emitted.
- in_state changing after accept has no effect, because the orig copy is used for feed-forward.

Optional Feature:
- Macro: SALSA_FEEDFORWARD_EN.
- Defined: FINAL registers out_state word i = work[i] + orig[i] (mod 2^32). This is the standard Salsa20 core output.
- Undefined: FINAL registers out_state = work (the raw permutation). The orig register bank is not instantiated and latency is unchanged.

Test Plan:
1. Reset, then idle 3 cycles -> in_ready=1, out_valid=0, busy=0, out_state=0.
2. ROUNDS=1, in_state word0=0x00000001 and all other words 0 -> out_state word0=0x08008145, word4=0x00000080, word8=0x00010200, word12=0x20500000, all others 0. The feed-forward macro adds 1 to word0, giving 0x08008146. out_valid rises in cycle 6.
3. ROUNDS=20, all-zero in_state -> all-zero out_state, out_valid in cycle 82. Random in_state x100 is compared against the software Salsa20/20 model, with and without SALSA_FEEDFORWARD_EN.
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_state stable, in_ready=0, and a new in_valid pulse is not accepted. Then set out_ready=1 -> out_valid drops next edge and in_ready=1.
5. Assert rst_n=0 for one cycle at step 37 of a ROUNDS=20 run -> the block is in IDLE next cycle, and the following hash of a known vector matches the model exactly.
6. Back-to-back streaming with in_valid and out_ready tied high for 5 vectors -> one result every 83 cycles, in order, all matching the model.
